// File: rtl/num_ctl.sv
// Number-conversion sequencer: fetch token, resolve base prefix, drive atoi, check terminator, push.
// Optional digit-limit overflow check enabled by defining NUMCTL_OVF_EN.
module num_ctl #(
    parameter int unsigned DSZ = 32,
    parameter int unsigned ASZ = 17,
    parameter int unsigned TMO = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [ASZ-1:0] ai,
    input  logic           hex_dflt,
    output logic [ASZ-1:0] ma,
    input  logic [7:0]     ch,
    output logic           a_en,
    output logic           a_hex,
    input  logic           a_bsy,
    input  logic           a_ao,
    input  logic [DSZ-1:0] a_vo,
    output logic           push,
    input  logic           push_rdy,
    output logic [DSZ-1:0] vo,
    output logic           bsy,
    output logic           done,
    output logic           err
);

    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        StIdle, StPfx, StPfw, StLch, StRun, StChk, StPsh, StFin
    } state_e;

    state_e         state_q, state_d;
    logic [ASZ-1:0] ma_q, ma_d;
    logic [DSZ-1:0] vo_q, vo_d;
    logic [7:0]     nd_q, nd_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           a_hex_q, a_hex_d;
    logic           err_q, err_d;
    logic           a_bsy_q;
    logic           term_ok;
    logic           over;

    assign term_ok = (ch == 8'h20) || (ch == 8'h00);

`ifdef NUMCTL_OVF_EN
    logic [7:0] nd_lim;
    assign nd_lim = a_hex_q ? 8'(DSZ / 4) : 8'd10;
    assign over   = (nd_q > nd_lim);
`else
    assign over = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        vo_d    = vo_q;
        nd_d    = nd_q;
        timer_d = timer_q;
        a_hex_d = a_hex_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    ma_d    = ai;
                    err_d   = 1'b0;
                    nd_d    = '0;
                    timer_d = '0;
                    a_hex_d = hex_dflt;
                    state_d = StPfx;
                end
            end
            StPfx: state_d = StPfw;
            StPfw: begin
                if (ch == 8'h24) begin
                    a_hex_d = 1'b1;
                    ma_d    = ma_q + ASZ'(1);
                end else if (ch == 8'h23) begin
                    a_hex_d = 1'b0;
                    ma_d    = ma_q + ASZ'(1);
                end
                state_d = StLch;
            end
            StLch: state_d = StRun;
            StRun: begin
                // '-' advances the address but is not a digit
                if (a_ao) begin
                    ma_d = ma_q + ASZ'(1);
                    if (ch != 8'h2d && nd_q != 8'hff) nd_d = nd_q + 8'd1;
                end
                if (timer_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (a_bsy_q && !a_bsy) begin
                        vo_d    = a_vo;
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (nd_q == 8'd0 || !term_ok || over) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    state_d = StPsh;
                end
            end
            StPsh: if (push_rdy) state_d = StFin;
            StFin: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ma_q    <= '0;
            vo_q    <= '0;
            nd_q    <= '0;
            timer_q <= '0;
            a_hex_q <= 1'b0;
            err_q   <= 1'b0;
            a_bsy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            vo_q    <= vo_d;
            nd_q    <= nd_d;
            timer_q <= timer_d;
            a_hex_q <= a_hex_d;
            err_q   <= err_d;
            a_bsy_q <= a_bsy;
        end
    end

    assign ma    = ma_q;
    assign vo    = vo_q;
    assign a_hex = a_hex_q;
    assign err   = err_q;
    assign a_en  = (state_q == StLch);
    assign push  = (state_q == StPsh);
    assign done  = (state_q == StFin);
    assign bsy   = (state_q != StIdle);

endmodule

// File: tb/tb_num_ctl.sv
// Scoreboard bench for num_ctl with byte-memory and atoi behavioural models.
module tb_num_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [16:0] ai;
    logic        hex_dflt;
    logic [16:0] ma;
    logic [7:0]  ch;
    logic        a_en;
    logic        a_hex;
    logic        a_bsy;
    logic        a_ao;
    logic [31:0] a_vo;
    logic        push;
    logic        push_rdy;
    logic [31:0] vo;
    logic        bsy;
    logic        done;
    logic        err;

    num_ctl dut (
        .clk(clk), .rst(rst), .req(req), .ai(ai), .hex_dflt(hex_dflt), .ma(ma), .ch(ch),
        .a_en(a_en), .a_hex(a_hex), .a_bsy(a_bsy), .a_ao(a_ao), .a_vo(a_vo), .push(push),
        .push_rdy(push_rdy), .vo(vo), .bsy(bsy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] vo;
        logic [16:0] ma;
        logic        hx;
    } push_t;

    push_t pq[$];
    logic  dq[$];

    logic [7:0] mem [0:131071];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Registered read port: ch reflects mem[ma] one cycle later
    always @(posedge clk) ch <= mem[ma];

    // atoi model: consumes one char every other cycle, stops on the first non-digit
    bit          hang = 0;
    bit          act = 0;
    bit          wt, neg, first;
    logic [31:0] acc;

    function automatic int dval(input logic [7:0] c, input logic hx);
        if (c >= 8'h30 && c <= 8'h39) return int'(c - 8'h30);
        if (hx && c >= 8'h61 && c <= 8'h66) return int'(c - 8'h61) + 10;
        if (hx && c >= 8'h41 && c <= 8'h46) return int'(c - 8'h41) + 10;
        return -1;
    endfunction

    always begin
        @(posedge clk);
        #1;
        a_ao = 1'b0;
        if (!rst || !bsy) begin
            act   = 0;
            a_bsy = 1'b0;
        end else if (a_en) begin
            act   = 1;
            a_bsy = 1'b1;
            acc   = '0;
            neg   = 0;
            first = 1;
            wt    = 0;
        end else if (act && !hang) begin
            if (wt) begin
                wt = 0;
            end else if (first && ch == 8'h2d) begin
                neg   = 1;
                first = 0;
                a_ao  = 1'b1;
                wt    = 1;
            end else if (dval(ch, a_hex) >= 0) begin
                acc   = acc * (a_hex ? 32'd16 : 32'd10) + 32'(dval(ch, a_hex));
                first = 0;
                a_ao  = 1'b1;
                wt    = 1;
            end else begin
                a_vo  = neg ? (~acc + 32'd1) : acc;
                a_bsy = 1'b0;
                act   = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT pushes or signals done
    bit          held = 0;
    bit          exp_done_next = 0;
    logic [31:0] held_vo;

    always @(negedge clk) begin
        if (!rst) begin
            held          = 0;
            exp_done_next = 0;
        end else begin
            if (exp_done_next) begin
                chk("done_after_push", 32'(done), 32'd1);
                exp_done_next = 0;
            end
            if (held) begin
                chk("push_held", 32'(push), 32'd1);
                chk("vo_held", vo, held_vo);
            end
            if (push && push_rdy) begin
                if (pq.size() == 0) begin
                    chk("unexpected_push", 32'd1, 32'd0);
                end else begin
                    push_t e;
                    e = pq.pop_front();
                    chk("push_vo", vo, e.vo);
                    chk("push_ma", 32'(ma), 32'(e.ma));
                    chk("push_hex", 32'(a_hex), 32'(e.hx));
                end
                exp_done_next = 1;
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("done_err", 32'(err), 32'(dq.pop_front()));
                end
                done_cnt++;
            end
            held    = push && !push_rdy;
            held_vo = vo;
        end
    end

    task automatic load(input logic [16:0] addr, input string s);
        for (int i = 0; i < s.len(); i++) mem[17'(addr + 17'(i))] = s[i];
        mem[17'(addr + 17'(s.len()))] = 8'h00;
    endtask

    task automatic run_vec(input logic [16:0] addr, input string s, input logic hexd,
                           input bit exp_push, input logic [31:0] exp_vo,
                           input logic [16:0] exp_ma, input logic exp_hx, input int stall);
        int start;
        push_t e;
        load(addr, s);
        if (exp_push) begin
            e.vo = exp_vo;
            e.ma = exp_ma;
            e.hx = exp_hx;
            pq.push_back(e);
        end
        dq.push_back(!exp_push);
        start    = done_cnt;
        push_rdy = (stall == 0);
        ai       = addr;
        hex_dflt = hexd;
        req      = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (stall > 0) begin
            for (int i = 0; i < 300 && !push; i++) begin
                @(posedge clk);
                #1;
            end
            repeat (stall) @(posedge clk);
            #1;
            push_rdy = 1'b1;
        end
        for (int i = 0; i < 300 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        push_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        rst      = 1'b0;
        req      = 1'b0;
        ai       = '0;
        hex_dflt = 1'b0;
        push_rdy = 1'b1;
        a_bsy    = 1'b0;
        a_ao     = 1'b0;
        a_vo     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ma", 32'(ma), 32'd0);
        chk("rst_vo", vo, 32'd0);
        chk("rst_ctl", {26'd0, a_en, a_hex, push, bsy, done, err}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_vec(17'h100, "123 ", 1'b0, 1, 32'd123, 17'h103, 1'b0, 0);
        run_vec(17'h200, "$-1f", 1'b0, 1, 32'hFFFFFFE1, 17'h204, 1'b1, 0);
        run_vec(17'h300, "12x ", 1'b0, 0, '0, '0, 1'b0, 0);
        run_vec(17'h400, "- ", 1'b0, 0, '0, '0, 1'b0, 0);
        run_vec(17'h500, "7 ", 1'b0, 1, 32'd7, 17'h501, 1'b0, 5);
        run_vec(17'h900, "#15 ", 1'b1, 1, 32'd15, 17'h903, 1'b0, 0);
        run_vec(17'hA00, "$ff ", 1'b0, 1, 32'd255, 17'hA03, 1'b1, 0);
        run_vec(17'h1FFFF, "9 ", 1'b0, 1, 32'd9, 17'h00000, 1'b0, 0);

        // Reset while the atoi is still running: nothing may be pushed or completed afterwards
        hang = 1;
        load(17'h600, "99 ");
        ai  = 17'h600;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int i = 0; i < 20 && !a_en; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("run_bsy", 32'(bsy), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_ma", 32'(ma), 32'd0);
        chk("midrst_ctl", {27'd0, a_en, a_hex, push, bsy, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        hang = 0;
        repeat (5) @(posedge clk);
        #1;
        run_vec(17'h700, "42 ", 1'b0, 1, 32'd42, 17'h702, 1'b0, 0);

        // atoi never finishes: RUN timeout ends with err and no push
        hang = 1;
        run_vec(17'h800, "5 ", 1'b0, 0, '0, '0, 1'b0, 0);
        hang = 0;
        repeat (2) @(posedge clk);
        #1;

`ifdef NUMCTL_OVF_EN
        run_vec(17'hB00, "12345678901 ", 1'b0, 0, '0, '0, 1'b0, 0);
`else
        run_vec(17'hB00, "12345678901 ", 1'b0, 1, 32'd3755744309, 17'hB0B, 1'b0, 0);
`endif

        repeat (5) @(posedge clk);
        chk("push_queue_empty", 32'(pq.size()), 32'd0);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/num_ctl.md
Name: num_ctl

Overview:
- Sequencer for the number-conversion datapath of the outer interpreter.
- On request it:
  - fetches a token from byte memory;
  - resolves a base prefix;
  - launches the atoi converter and steps its character feed;
  - validates the terminator;
  - pushes the converted value to the data-stack writer with a ready/valid handshake.
- Sits between the token scanner (requester), the shared memory read port and the data stack.

Parameters:
- DSZ, 32, data/value width.
- ASZ, 17, byte-address width.
- TMO, 64, maximum cycles spent in RUN before timeout error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  1  start-conversion pulse; sampled only in IDLE.
- ai  in  ASZ  token start address.
- hex_dflt  in  1  current BASE: 0 = decimal, 1 = hex.
- ma  out  ASZ  memory read address; data returns on ch one cycle later.
- ch  in  8  memory read data.
- a_en  out  1  atoi enable, a one-cycle pulse.
- a_hex  out  1  base select to atoi, held stable through RUN.
- a_bsy  in  1  atoi busy.
- a_ao  in  1  atoi advance-address request.
- a_vo  in  DSZ  atoi result.
- push  out  1  push-valid to the data stack.
- push_rdy  in  1  data stack accepts.
- vo  out  DSZ  value to push.
- bsy  out  1  controller busy.
- done  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid with done, held until the next req.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state goes to IDLE;
  - ma, vo, nd, timer cleared;
  - a_en, a_hex, push, bsy, done, err = 0.
  - Reset during any state aborts the conversion; no push is issued afterwards.
- States: IDLE, PFX, PFW, LCH, RUN, CHK, PSH, FIN.
- IDLE:
  - on req: ma <= ai, bsy <= 1, err <= 0, nd <= 0, a_hex <= hex_dflt; go to PFX.
  - req while bsy = 1 is ignored.
- PFX: wait one cycle for memory latency.
- PFW (ch is valid):
  - ch == "$": a_hex <= 1, ma <= ma + 1.
  - ch == "#": a_hex <= 0, ma <= ma + 1.
  - Otherwise ma is unchanged.
  - Go to LCH.
- LCH: wait one cycle for ch at the post-prefix address, assert a_en for exactly this cycle, go to RUN.
- RUN:
  - each a_ao pulse: ma <= ma + 1.
  - if ch != "-" at that same cycle: nd <= nd + 1 (saturating at 255).
  - When a_bsy falls (1 to 0): latch vo <= a_vo, go to CHK.
  - The timer counts cycles in RUN. At timer == TMO-1: err <= 1, go to FIN (timeout, no push).
- CHK:
  - ch is the terminator at the current ma.
  - err <= 1 if nd == 0, or if ch is neither 8'h20 nor 8'h00.
  - err = 1: go to FIN. Otherwise go to PSH.
- PSH:
  - push = 1 and vo stable until push_rdy = 1 is sampled.
  - The handshake completes in that cycle; go to FIN.
  - push_rdy may stay low indefinitely; no timeout applies in PSH.
- FIN: done = 1 for one cycle, bsy <= 0, go to IDLE.
- A req arriving in the same cycle as FIN is not accepted; it is accepted on the following IDLE cycle.
- Address arithmetic: ma is modulo 2^ASZ; wrap-around is allowed, not an error.
- Latency, e.g. "12 ": 4 cycles to the a_en pulse, plus atoi run time, plus CHK, PSH, FIN (minimum 3 with push_rdy = 1).

Optional Feature:
- Macro: NUMCTL_OVF_EN.
- When defined:
  - CHK also sets err = 1 if nd exceeds the digit limit: 10 when a_hex = 0, DSZ/4 when a_hex = 1.
  - An err caused by the digit limit suppresses the push.
- When undefined: no digit-limit check; overflowed values are pushed truncated to DSZ bits.

Test Plan:
- "123 " at ai = 'h100, hex_dflt = 0, push_rdy = 1:
  - push with vo = 123, err = 0, done;
  - ma = 'h103 at CHK.
- "$-1f\0" with hex_dflt = 0:
  - a_hex = 1, vo = -31 (32'hFFFFFFE1), err = 0;
  - prefix advanced ma by 1.
- "12x ": terminator "x" gives err = 1, done, no push.
- "- ": nd = 0 gives err = 1, no push.
- "7 " with push_rdy held low 5 cycles: push and vo held stable; done follows 1 cycle after push_rdy.
- Reset mid-run:
  - rst low during RUN: outputs cleared immediately, no push/done after release;
  - a new req on "42 " then pushes 42.
  - With NUMCTL_OVF_EN, "12345678901 " gives err = 1, no push.
